wavetable_oscillator: RTL and testbench
=======================================

# wavetable_oscillator

Programmable single-cycle wavetable voice that fills the empty wavetable channel of the 6-channel waveform mixer. It is loaded by the host over the I2C register bank through the `wavetable_idx`, `wavetable_data` and `wavetable_ctrl` registers. It plays back from the shared 24-bit phase accumulator, with optional linear interpolation between adjacent entries. The 8-bit unsigned sample output connects directly to the mixer's `wavetable_in`.

## Interface
Parameters:
- `DEPTH_LOG2`, 5: table depth is 2^DEPTH_LOG2 entries (32).
- `PHASE_W`, 24: phase input width.
- `FRAC_W`, 8: interpolation fraction width, taken from the phase bits directly below the index.

Ports:
- `clk` in 1: system clock. One clock domain only.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: oscillator run enable (`reg_control[0] & ena`).
- `phase_in` in PHASE_W: phase from the phase accumulator.
- `wt_idx` in 8: table write address. Only the low DEPTH_LOG2 bits are used.
- `wt_data` in 8: table write data.
- `wt_ctrl` in 8: command byte.
  - bit0 WRITE
  - bit1 AUTO_INC
  - bit2 INTERP_EN
  - bit3 CLEAR
  - bits 7:4 reserved, ignored.
- `wt_ctrl_wr` in 1: one-cycle strobe, high when the I2C bank writes `wavetable_ctrl`.
- `wave_out` out 8: unsigned sample to the mixer.
- `busy` out 1: a command is executing.
- `cmd_dropped` out 1: sticky flag, set when a command strobe arrives while busy.

## Operation
- Storage is 2^DEPTH_LOG2 x 8 flops. Reset loads every entry with 0x80 (mid-scale).
- Command FSM has three states: IDLE, WRITE, CLEAR.
  - IDLE → WRITE: `wt_ctrl_wr` with bit0=1 and bit3=0. The data and address are captured on the strobe edge.
  - IDLE → CLEAR: `wt_ctrl_wr` with bit3=1. CLEAR takes priority over WRITE when both bits are set.
  - WRITE: one cycle, then back to IDLE.
  - CLEAR: writes 0x80 to entries 0..DEPTH-1, one per cycle, in ascending order. After the last entry it returns to IDLE.
- Write address:
  - AUTO_INC=0: address is `wt_idx[DEPTH_LOG2-1:0]`. The write also loads the internal pointer with that address + 1.
  - AUTO_INC=1: address is the internal pointer, which then increments, wrapping DEPTH-1 → 0.
  - CLEAR resets the pointer to 0.
- INTERP_EN is latched on every `wt_ctrl_wr`, including strobes that are dropped. Its reset value is 0.
- Playback:
  - Index `a = phase_in[PHASE_W-1 -: DEPTH_LOG2]`; neighbour `b = a+1` modulo DEPTH, so entry DEPTH-1 interpolates toward entry 0.
  - Fraction `f = phase_in[PHASE_W-DEPTH_LOG2-1 -: FRAC_W]`.
  - INTERP_EN=0: output is `s[a]`.
  - INTERP_EN=1: `d = s[b] - s[a]`, 9-bit signed; `p = d*f`, 17-bit signed; output is `s[a] + (p >>> FRAC_W)`, arithmetic shift, i.e. floor. The result always lies in [min, max] of the two samples, so no saturation is needed.
- `enable`=0: the pipeline holds and `wave_out` is forced to 0x80 on the next cycle. Table writes and commands still work.
- Same-cycle read and write of one entry: playback sees the old value. The new value is visible the following cycle.

## Timing
- Playback latency is 2 cycles: phase registered with sample fetch → interpolate → `wave_out` register.
- WRITE: `busy` is high for 1 cycle after the strobe; the entry updates on that cycle's edge.
- CLEAR: `busy` is high for DEPTH cycles (32), starting the cycle after the strobe.
- Strobe while `busy`=1: the command is ignored and `cmd_dropped` sets the next cycle. `cmd_dropped` clears only on `rst`.
- Reset values: `wave_out`=0x80, `busy`=0, `cmd_dropped`=0, pointer=0, FSM=IDLE.
- Reset asserted mid-CLEAR: the FSM aborts to IDLE and all entries return to 0x80.

## Structure
- Shared package `synth_pkg` holds:
  - WT_CTRL bit positions (WRITE, AUTO_INC, INTERP_EN, CLEAR);
  - `MIDSCALE` = 8'h80;
  - the command FSM state enum.
- One sub-module, `wavetable_lerp`: a registered 8-bit linear interpolator with inputs `s0`, `s1`, `frac`, `interp_en`. The top level holds the table, FSM and pointer.

## Test plan
- Reset, then enable with any phase → `wave_out`=0x80 after 2 cycles; `busy`=0.
- Write idx 3 = 0x40 (AUTO_INC=0, INTERP_EN=0), then phase=0x180000 → `wave_out`=0x40 2 cycles later; `busy` high exactly 1 cycle.
- Enable interpolation and check the wrap neighbour:
  - Stimulus: AUTO_INC writes 0x00 and 0xFF starting at idx 30, so entry 30=0x00 and entry 31=0xFF; set INTERP_EN.
  - phase=0xF40000 (a=30, f=0x80) → 0x7F.
  - With entry 0=0x80: phase=0xFFFFFF (a=31, f=0xFF) → 0xFF + floor(-127×255/256) = 0x80.
- CLEAR after filling the table with 0xAA → `busy` high 32 cycles; every index then reads 0x80. A WRITE strobe at cycle 10 of the CLEAR is ignored and sets `cmd_dropped`.
- Assert `rst` at cycle 5 of a CLEAR → next cycle `busy`=0, all entries 0x80, `cmd_dropped`=0.
- Drop `enable` during playback → `wave_out`=0x80 the next cycle. A WRITE issued while disabled still updates the table, and the new value is observed after re-enable.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice blocks: wavetable command byte layout,
// the mid-scale sample value and the wavetable command FSM states.
package synth_pkg;

  localparam int WT_WRITE_BIT     = 0;
  localparam int WT_AUTO_INC_BIT  = 1;
  localparam int WT_INTERP_EN_BIT = 2;
  localparam int WT_CLEAR_BIT     = 3;

  localparam logic [7:0] MIDSCALE = 8'h80;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_CLEAR = 2'd2
  } cmd_state_e;

endpackage

// File: rtl/wavetable_lerp.sv
// Registered linear interpolator between two unsigned 8-bit samples; the
// registered result is forced to mid-scale while the voice is disabled.
module wavetable_lerp
  import synth_pkg::*;
#(
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [7:0]        s0,
  input  logic [7:0]        s1,
  input  logic [FRAC_W-1:0] frac,
  input  logic              interp_en,
  output logic [7:0]        sample
);

  localparam int PROD_W = FRAC_W + 9;

  logic signed [8:0]        diff;
  logic signed [PROD_W-1:0] prod;
  logic [7:0]               step;
  logic [7:0]               lerp_val;
  logic                     unused_prod;

  // Bits [FRAC_W+7:FRAC_W] of the two's-complement product are floor(p/2^FRAC_W)
  // modulo 256, which is all the 8-bit sum needs since the result stays in range.
  always_comb begin
    diff     = $signed({1'b0, s1}) - $signed({1'b0, s0});
    prod     = PROD_W'(diff) * PROD_W'($signed({1'b0, frac}));
    step     = prod[FRAC_W +: 8];
    lerp_val = interp_en ? (s0 + step) : s0;
  end

  assign unused_prod = ^{prod[FRAC_W-1:0], prod[PROD_W-1:FRAC_W+8]};

  always_ff @(posedge clk) begin
    if (rst) begin
      sample <= MIDSCALE;
    end else if (!enable) begin
      sample <= MIDSCALE;
    end else begin
      sample <= lerp_val;
    end
  end

endmodule

// File: rtl/wavetable_oscillator.sv
// Host-loadable single-cycle wavetable voice: flop table, write/clear command
// FSM with auto-increment pointer, and a two-stage playback pipeline.
module wavetable_oscillator
  import synth_pkg::*;
#(
  parameter int DEPTH_LOG2 = 5,
  parameter int PHASE_W    = 24,
  parameter int FRAC_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [PHASE_W-1:0] phase_in,
  input  logic [7:0]         wt_idx,
  input  logic [7:0]         wt_data,
  input  logic [7:0]         wt_ctrl,
  input  logic               wt_ctrl_wr,
  output logic [7:0]         wave_out,
  output logic               busy,
  output logic               cmd_dropped
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] LAST_IDX = DEPTH_LOG2'(DEPTH - 1);
  localparam logic [DEPTH_LOG2-1:0] ONE_IDX  = DEPTH_LOG2'(1);

  logic [7:0]            table_q [DEPTH];
  cmd_state_e            state_q;
  logic [DEPTH_LOG2-1:0] ptr_q;
  logic [DEPTH_LOG2-1:0] wr_addr_q;
  logic [7:0]            wr_data_q;
  logic [DEPTH_LOG2-1:0] clear_cnt_q;
  logic                  interp_en_q;
  logic                  cmd_dropped_q;

  logic [DEPTH_LOG2-1:0] cmd_addr;
  logic                  cmd_clear;
  logic                  cmd_write;

  logic [DEPTH_LOG2-1:0] idx_a;
  logic [DEPTH_LOG2-1:0] idx_b;
  logic [FRAC_W-1:0]     frac;
  logic [7:0]            s0_q;
  logic [7:0]            s1_q;
  logic [FRAC_W-1:0]     frac_q;
  logic                  unused_inputs;

  // CLEAR wins over WRITE when both command bits are set.
  always_comb begin
    cmd_clear = wt_ctrl[WT_CLEAR_BIT];
    cmd_write = wt_ctrl[WT_WRITE_BIT] & ~wt_ctrl[WT_CLEAR_BIT];
    cmd_addr  = wt_ctrl[WT_AUTO_INC_BIT] ? ptr_q : wt_idx[DEPTH_LOG2-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= CMD_IDLE;
      ptr_q         <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      clear_cnt_q   <= '0;
      interp_en_q   <= 1'b0;
      cmd_dropped_q <= 1'b0;
    end else begin
      if (wt_ctrl_wr) begin
        interp_en_q <= wt_ctrl[WT_INTERP_EN_BIT];
      end
      if (wt_ctrl_wr && (state_q != CMD_IDLE)) begin
        cmd_dropped_q <= 1'b1;
      end
      case (state_q)
        CMD_IDLE: begin
          if (wt_ctrl_wr && cmd_clear) begin
            state_q     <= CMD_CLEAR;
            clear_cnt_q <= '0;
            ptr_q       <= '0;
          end else if (wt_ctrl_wr && cmd_write) begin
            state_q   <= CMD_WRITE;
            wr_addr_q <= cmd_addr;
            wr_data_q <= wt_data;
            ptr_q     <= cmd_addr + ONE_IDX;
          end
        end
        CMD_WRITE: begin
          state_q <= CMD_IDLE;
        end
        CMD_CLEAR: begin
          clear_cnt_q <= clear_cnt_q + ONE_IDX;
          if (clear_cnt_q == LAST_IDX) begin
            state_q <= CMD_IDLE;
          end
        end
        default: begin
          state_q <= CMD_IDLE;
        end
      endcase
    end
  end

  // Table storage; reset alone restores mid-scale, even in the middle of a CLEAR.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= MIDSCALE;
      end
    end else if (state_q == CMD_WRITE) begin
      table_q[wr_addr_q] <= wr_data_q;
    end else if (state_q == CMD_CLEAR) begin
      table_q[clear_cnt_q] <= MIDSCALE;
    end
  end

  assign idx_a = phase_in[PHASE_W-1 -: DEPTH_LOG2];
  assign idx_b = idx_a + ONE_IDX;
  assign frac  = phase_in[PHASE_W-DEPTH_LOG2-1 -: FRAC_W];

  // Fetch stage reads the pre-write table contents on a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q   <= MIDSCALE;
      s1_q   <= MIDSCALE;
      frac_q <= '0;
    end else if (enable) begin
      s0_q   <= table_q[idx_a];
      s1_q   <= table_q[idx_b];
      frac_q <= frac;
    end
  end

  wavetable_lerp #(
    .FRAC_W(FRAC_W)
  ) u_lerp (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .s0       (s0_q),
    .s1       (s1_q),
    .frac     (frac_q),
    .interp_en(interp_en_q),
    .sample   (wave_out)
  );

  assign busy        = (state_q != CMD_IDLE);
  assign cmd_dropped = cmd_dropped_q;

  assign unused_inputs = ^{phase_in[PHASE_W-DEPTH_LOG2-FRAC_W-1:0],
                           wt_ctrl[7:4], wt_idx[7:DEPTH_LOG2]};

endmodule

// File: tb/tb_wavetable_oscillator.sv
// Directed plus randomized bench for wavetable_oscillator, checked against a
// table-level reference model of the command and playback behaviour.
module tb_wavetable_oscillator;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [23:0] phase_in;
  logic [7:0]  wt_idx;
  logic [7:0]  wt_data;
  logic [7:0]  wt_ctrl;
  logic        wt_ctrl_wr;
  logic [7:0]  wave_out;
  logic        busy;
  logic        cmd_dropped;

  int compared   = 0;
  int mismatched = 0;

  int model_tbl [32];
  int model_ptr;
  bit model_interp;

  wavetable_oscillator dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .phase_in   (phase_in),
    .wt_idx     (wt_idx),
    .wt_data    (wt_data),
    .wt_ctrl    (wt_ctrl),
    .wt_ctrl_wr (wt_ctrl_wr),
    .wave_out   (wave_out),
    .busy       (busy),
    .cmd_dropped(cmd_dropped)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %02h expected %02h", tag, observed, expected);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < 32; i++) model_tbl[i] = 8'h80;
    model_ptr    = 0;
    model_interp = 1'b0;
  endfunction

  function automatic void modelCommand(input logic [7:0] ctrl, input logic [7:0] idx, input logic [7:0] data);
    int addr;
    model_interp = ctrl[2];
    if (ctrl[3]) begin
      for (int i = 0; i < 32; i++) model_tbl[i] = 8'h80;
      model_ptr = 0;
    end else if (ctrl[0]) begin
      addr = ctrl[1] ? model_ptr : (int'(idx) % 32);
      model_tbl[addr] = int'(data);
      model_ptr = (addr + 1) % 32;
    end
  endfunction

  function automatic logic [7:0] refSample(input logic [23:0] ph);
    int a, b, f, sa, sb, p, q;
    a  = int'(ph) / 524288;
    f  = (int'(ph) / 2048) % 256;
    b  = (a + 1) % 32;
    sa = model_tbl[a];
    sb = model_tbl[b];
    if (!model_interp) return sa[7:0];
    p = (sb - sa) * f;
    q = p / 256;
    if (p < 0 && (p % 256) != 0) q = q - 1;
    q = sa + q;
    return q[7:0];
  endfunction

  // Issue one command strobe (only while idle) and mirror it in the model.
  task automatic applyStimulus(input logic [7:0] ctrl, input logic [7:0] idx, input logic [7:0] data);
    wt_ctrl    = ctrl;
    wt_idx     = idx;
    wt_data    = data;
    wt_ctrl_wr = 1'b1;
    tick();
    wt_ctrl_wr = 1'b0;
    modelCommand(ctrl, idx, data);
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checkOutput(tag, {7'd0, busy}, 8'd0);
  endtask

  task automatic readExpect(input string tag, input logic [23:0] ph, input logic [7:0] expected);
    phase_in = ph;
    tick();
    tick();
    checkOutput(tag, wave_out, expected);
  endtask

  task automatic readCheck(input string tag, input logic [23:0] ph);
    readExpect(tag, ph, refSample(ph));
  endtask

  initial begin
    int cycles;
    logic [7:0] ctrl;
    rst        = 1'b1;
    enable     = 1'b0;
    phase_in   = '0;
    wt_idx     = '0;
    wt_data    = '0;
    wt_ctrl    = '0;
    wt_ctrl_wr = 1'b0;
    modelReset();
    repeat (3) tick();
    rst = 1'b0;

    checkOutput("reset_wave_out", wave_out, 8'h80);
    checkOutput("reset_busy", {7'd0, busy}, 8'd0);
    checkOutput("reset_dropped", {7'd0, cmd_dropped}, 8'd0);

    enable = 1'b1;
    readExpect("enable_midscale", 24'($urandom_range(0, 24'hFFFFFF)), 8'h80);

    // Plain write of entry 3 and busy pulse width.
    applyStimulus(8'h01, 8'd3, 8'h40);
    checkOutput("write_busy_high", {7'd0, busy}, 8'd1);
    tick();
    checkOutput("write_busy_low", {7'd0, busy}, 8'd0);
    readExpect("write_idx3", 24'h180000, 8'h40);

    // Auto-increment across the top of the table, interpolation on.
    applyStimulus(8'h05, 8'd30, 8'h00);
    waitIdle("wait_w30");
    applyStimulus(8'h07, 8'd0, 8'hFF);
    waitIdle("wait_w31");
    readExpect("interp_mid", 24'hF40000, 8'h7F);
    readExpect("interp_wrap", 24'hFFFFFF, 8'h80);
    applyStimulus(8'h07, 8'd0, 8'h10);
    waitIdle("wait_wrap_ptr");
    readExpect("autoinc_wrap_entry0", 24'h000000, 8'h10);

    // Fill with 0xAA, then CLEAR with a WRITE attempt in the middle.
    applyStimulus(8'h01, 8'd0, 8'hAA);
    waitIdle("wait_fill0");
    for (int i = 1; i < 32; i++) begin
      applyStimulus(8'h03, 8'd0, 8'hAA);
      waitIdle("wait_fill");
    end
    readExpect("fill_idx17", 24'(17) << 19, 8'hAA);
    applyStimulus(8'h08, 8'd0, 8'd0);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      if (cycles == 10) begin
        wt_ctrl    = 8'h01;
        wt_idx     = 8'd2;
        wt_data    = 8'h11;
        wt_ctrl_wr = 1'b1;
      end else begin
        wt_ctrl_wr = 1'b0;
      end
      tick();
    end
    wt_ctrl_wr   = 1'b0;
    model_interp = 1'b0;
    checkOutput("clear_busy_cycles", 8'(cycles), 8'd32);
    checkOutput("clear_dropped", {7'd0, cmd_dropped}, 8'd1);
    for (int i = 0; i < 32; i++) begin
      readExpect($sformatf("clear_idx%0d", i), 24'(i) << 19, 8'h80);
    end

    // Reset in the middle of a CLEAR.
    applyStimulus(8'h01, 8'd20, 8'h33);
    waitIdle("wait_w20");
    applyStimulus(8'h08, 8'd0, 8'd0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    modelReset();
    checkOutput("rst_clear_busy", {7'd0, busy}, 8'd0);
    checkOutput("rst_clear_dropped", {7'd0, cmd_dropped}, 8'd0);
    checkOutput("rst_clear_wave", wave_out, 8'h80);
    readExpect("rst_clear_idx20", 24'(20) << 19, 8'h80);

    // Disable during playback; a write while disabled lands in the table.
    applyStimulus(8'h01, 8'd9, 8'h5A);
    waitIdle("wait_w9");
    readExpect("play_idx9", 24'(9) << 19, 8'h5A);
    enable = 1'b0;
    tick();
    checkOutput("disable_midscale", wave_out, 8'h80);
    applyStimulus(8'h01, 8'd9, 8'hC3);
    waitIdle("wait_w9b");
    checkOutput("disabled_hold", wave_out, 8'h80);
    enable = 1'b1;
    tick();
    tick();
    checkOutput("reenable_new_value", wave_out, 8'hC3);

    // A dropped strobe still latches INTERP_EN.
    applyStimulus(8'h01, 8'd0, 8'h00);
    wt_ctrl    = 8'h04;
    wt_ctrl_wr = 1'b1;
    tick();
    wt_ctrl_wr   = 1'b0;
    model_interp = 1'b1;
    checkOutput("write_drop_flag", {7'd0, cmd_dropped}, 8'd1);
    waitIdle("wait_drop");
    readExpect("dropped_interp_latch", 24'h040000, 8'h40);

    // Randomized commands against the reference model.
    for (int it = 0; it < 40; it++) begin
      ctrl = 8'h01;
      ctrl[1] = 1'($urandom_range(0, 1));
      ctrl[2] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) ctrl[3] = 1'b1;
      ctrl[7:4] = 4'($urandom_range(0, 15));
      applyStimulus(ctrl, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      waitIdle("rand_wait");
      for (int k = 0; k < 2; k++) begin
        readCheck($sformatf("rand_it%0d_%0d", it, k), 24'($urandom_range(0, 24'hFFFFFF)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
